// File: rtl/egreedy_action_selector_pkg.sv
// Shared types and constants for the epsilon-greedy action selector.
package egreedy_action_selector_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_READ   = 2'd1,
    S_DECIDE = 2'd2,
    S_HOLD   = 2'd3
  } fsm_e;

  localparam int unsigned ACT_W = 2;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, shifting every cycle outside reset.
module lfsr16
  import egreedy_action_selector_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] seed,
  output logic [15:0] out
);

  logic [15:0] lfsr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= seed;
    end else begin
      lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  assign out = lfsr_q;

endmodule

// File: rtl/egreedy_action_selector.sv
// Epsilon-greedy policy stage: reads four Q values for a state and emits a greedy or random action.
module egreedy_action_selector
  import egreedy_action_selector_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter logic [7:0]  EPS_INIT  = 8'd200,
  parameter logic [7:0]  EPS_MIN   = 8'd8,
  parameter logic [7:0]  EPS_STEP  = 8'd4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] state,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] q0,
  input  logic [DATA_W-1:0] q1,
  input  logic [DATA_W-1:0] q2,
  input  logic [DATA_W-1:0] q3,
  output logic              act_valid,
  input  logic              act_ready,
  output logic [ACT_W-1:0]  action,
  output logic [ADDR_W-1:0] act_state,
  output logic              explore,
  input  logic              decay,
  output logic [7:0]        epsilon
);

  // An all-zero seed would lock the LFSR up
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [8:0]  EPS_THRESH = {1'b0, EPS_MIN} + {1'b0, EPS_STEP};

  fsm_e fsm_q, fsm_d;
  logic              init_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] q0_q, q1_q, q2_q, q3_q;
  logic              act_valid_q;
  logic [ACT_W-1:0]  action_q;
  logic              explore_q;
  logic [7:0]        eps_q;
  logic [15:0]       lfsr;
  logic              unused_lfsr;
  logic              accept;
  logic              rnd_pick;
  logic [ACT_W-1:0]  greedy_idx, i01, i23;
  logic [DATA_W-1:0] m01, m23;

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .seed  (SEED),
    .out   (lfsr)
  );

  assign unused_lfsr = ^lfsr[15:10];

  assign st_ready = (fsm_q == S_IDLE) && init_q;
  assign accept   = st_valid && st_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q <= S_IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      S_IDLE:   if (accept) fsm_d = S_READ;
      S_READ:   fsm_d = S_DECIDE;
      S_DECIDE: fsm_d = S_HOLD;
      S_HOLD:   if (act_ready) fsm_d = S_IDLE;
      default:  fsm_d = S_IDLE;
    endcase
  end

  // Index-carrying max tree; ties take the higher index
  always_comb begin
    m01 = q0_q;
    i01 = 2'd0;
    if (q1_q >= q0_q) begin
      m01 = q1_q;
      i01 = 2'd1;
    end
    m23 = q2_q;
    i23 = 2'd2;
    if (q3_q >= q2_q) begin
      m23 = q3_q;
      i23 = 2'd3;
    end
    greedy_idx = (m23 >= m01) ? i23 : i01;
  end

  assign rnd_pick = (lfsr[7:0] < eps_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q      <= 1'b0;
      addr_q      <= '0;
      q0_q        <= '0;
      q1_q        <= '0;
      q2_q        <= '0;
      q3_q        <= '0;
      act_valid_q <= 1'b0;
      action_q    <= '0;
      explore_q   <= 1'b0;
      eps_q       <= EPS_INIT;
    end else begin
      init_q <= 1'b1;
      if (accept) addr_q <= state;
      if (fsm_q == S_READ) begin
        q0_q <= q0;
        q1_q <= q1;
        q2_q <= q2;
        q3_q <= q3;
      end
      if (fsm_q == S_DECIDE) begin
        action_q    <= rnd_pick ? lfsr[9:8] : greedy_idx;
        explore_q   <= rnd_pick;
        act_valid_q <= 1'b1;
      end else if (fsm_q == S_HOLD && act_ready) begin
        act_valid_q <= 1'b0;
      end
      // DECIDE above reads eps_q, so a coincident pulse only affects later decisions
      if (decay) begin
        eps_q <= ({1'b0, eps_q} >= EPS_THRESH) ? (eps_q - EPS_STEP) : EPS_MIN;
      end
    end
  end

  assign rd_addr   = addr_q;
  assign act_state = addr_q;
  assign act_valid = act_valid_q;
  assign action    = action_q;
  assign explore   = explore_q;
  assign epsilon   = eps_q;

endmodule
